mem_ld: RTL and testbench

- Load unit sitting directly upstream of the memory read stage in the CPU data path.
- Accepts one load request from execute: address plus RISC-V funct3 size/sign code.
- Issues word-aligned read strobes to the read stage and waits for its done pulse.
- Extracts the byte, half or word and sign- or zero-extends it, then returns one result pulse to writeback.

---
 rtl/mem_ld.sv | 196 +++++++++++++++++++
 tb/tb_mem_ld.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ld.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ld
//  Brief    : Load unit ahead of the memory read stage. Issues word-aligned
//             read strobes, then extracts and sign/zero-extends a byte, half
//             or word. Define MEM_LD_MISALIGN_EN to serve misaligned loads
//             (two reads when the access crosses a word boundary).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ld #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ld_req_i,
    input  logic [XLEN-1:0] ld_addr_i,
    input  logic [2:0]      ld_funct3_i,
    output logic            ld_ready_o,
    output logic            ld_valid_o,
    output logic [XLEN-1:0] ld_data_o,
    output logic            ld_err_o,
    output logic            rd_en_o,
    output logic [XLEN-1:0] rd_addr_o,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            rd_done_i
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("mem_ld supports only XLEN = 32");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_word0;

    logic            w_illegal;
    logic            w_mis;
    logic            w_reject;
    logic [XLEN-1:0] w_word0;
    logic [XLEN-1:0] w_word1;
    logic [2*XLEN-1:0] w_pair;
    logic [XLEN-1:0] w_low;
    logic [XLEN-1:0] w_ext;

    assign ld_ready_o = (r_state == S_IDLE) && !rst_i;

    assign w_illegal = !((ld_funct3_i == c_f3_lb)  || (ld_funct3_i == c_f3_lh) ||
                         (ld_funct3_i == c_f3_lw)  || (ld_funct3_i == c_f3_lbu) ||
                         (ld_funct3_i == c_f3_lhu));

    // funct3[1:0] encodes the size: 00 byte, 01 half, 10 word
    always_comb begin
        w_mis = 1'b0;
        case (ld_funct3_i[1:0])
            2'b01:   w_mis = ld_addr_i[0];
            2'b10:   w_mis = (ld_addr_i[1:0] != 2'b00);
            default: w_mis = 1'b0;
        endcase
    end

`ifdef MEM_LD_MISALIGN_EN
    logic [XLEN-1:0] r_word1;
    logic            r_cross;
    logic            w_cross;

    always_comb begin
        w_cross = 1'b0;
        case (ld_funct3_i[1:0])
            2'b01:   w_cross = (ld_addr_i[1:0] == 2'b11);
            2'b10:   w_cross = (ld_addr_i[1:0] != 2'b00);
            default: w_cross = 1'b0;
        endcase
    end

    assign w_reject = w_illegal;
    assign w_word1  = (r_state == S_WAIT1) ? rd_data_i : r_word1;
`else
    assign w_reject = w_illegal || w_mis;
    assign w_word1  = '0;
`endif

    // Word0 is taken straight from the read bus on the cycle it arrives
    assign w_word0 = (r_state == S_WAIT0) ? rd_data_i : r_word0;
    assign w_pair  = {w_word1, w_word0} >> {r_addr[1:0], 3'b000};
    assign w_low   = w_pair[XLEN-1:0];

    always_comb begin
        w_ext = '0;
        case (r_funct3)
            c_f3_lb:  w_ext = {{(XLEN-8){w_low[7]}}, w_low[7:0]};
            c_f3_lh:  w_ext = {{(XLEN-16){w_low[15]}}, w_low[15:0]};
            c_f3_lw:  w_ext = w_low;
            c_f3_lbu: w_ext = {{(XLEN-8){1'b0}}, w_low[7:0]};
            c_f3_lhu: w_ext = {{(XLEN-16){1'b0}}, w_low[15:0]};
            default:  w_ext = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_word0    <= '0;
`ifdef MEM_LD_MISALIGN_EN
            r_word1    <= '0;
            r_cross    <= 1'b0;
`endif
            ld_valid_o <= 1'b0;
            ld_data_o  <= '0;
            ld_err_o   <= 1'b0;
            rd_en_o    <= 1'b0;
            rd_addr_o  <= '0;
        end else begin
            rd_en_o    <= 1'b0;
            ld_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ld_req_i) begin
                        r_addr   <= ld_addr_i;
                        r_funct3 <= ld_funct3_i;
`ifdef MEM_LD_MISALIGN_EN
                        r_word1  <= '0;
                        r_cross  <= w_cross;
`endif
                        if (w_reject) begin
                            r_state    <= S_RESP;
                            ld_valid_o <= 1'b1;
                            ld_err_o   <= 1'b1;
                            ld_data_o  <= '0;
                        end else begin
                            r_state   <= S_REQ0;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= {ld_addr_i[XLEN-1:2], 2'b00};
                        end
                    end
                end
                S_REQ0: r_state <= S_WAIT0;
                S_WAIT0: begin
                    if (rd_done_i) begin
                        r_word0 <= rd_data_i;
`ifdef MEM_LD_MISALIGN_EN
                        if (r_cross) begin
                            r_state   <= S_REQ1;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= rd_addr_o + XLEN'(4);
                        end else begin
                            r_state    <= S_RESP;
                            ld_valid_o <= 1'b1;
                            ld_err_o   <= 1'b0;
                            ld_data_o  <= w_ext;
                        end
`else
                        r_state    <= S_RESP;
                        ld_valid_o <= 1'b1;
                        ld_err_o   <= 1'b0;
                        ld_data_o  <= w_ext;
`endif
                    end
                end
`ifdef MEM_LD_MISALIGN_EN
                S_REQ1: r_state <= S_WAIT1;
                S_WAIT1: begin
                    if (rd_done_i) begin
                        r_word1    <= rd_data_i;
                        r_state    <= S_RESP;
                        ld_valid_o <= 1'b1;
                        ld_err_o   <= 1'b0;
                        ld_data_o  <= w_ext;
                    end
                end
`endif
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ld.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ld
//  Brief    : Directed vector bench for mem_ld with a one-cycle read stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ld;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_funct3 = '0;
    logic        ld_ready, ld_valid, ld_err, rd_en, rd_done;
    logic [31:0] ld_data, rd_addr, rd_data;

    mem_ld #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ld_req_i    (ld_req),
        .ld_addr_i   (ld_addr),
        .ld_funct3_i (ld_funct3),
        .ld_ready_o  (ld_ready),
        .ld_valid_o  (ld_valid),
        .ld_data_o   (ld_data),
        .ld_err_o    (ld_err),
        .rd_en_o     (rd_en),
        .rd_addr_o   (rd_addr),
        .rd_data_i   (rd_data),
        .rd_done_i   (rd_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // Read stage model: done one cycle after each strobe
    logic        pend = 1'b0, resp_en = 1'b1, stray = 1'b0;
    logic [31:0] pend_data = '0;
    int          en_cnt = 0;
    logic [31:0] addr_log [2];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8765_4321;
            32'h0000_0104: return 32'hCAFE_BABE;
            32'hFFFF_FFFC: return 32'h1122_3344;
            default:       return 32'h0;
        endcase
    endfunction

    initial begin
        rd_done = 1'b0;
        rd_data = '0;
    end

    always @(posedge clk) begin
        #1;
        rd_done   = pend | stray;
        rd_data   = pend ? pend_data : 32'hDEAD_BEEF;
        pend      = rd_en & resp_en;
        pend_data = mem_rd(rd_addr);
        if (rd_en) begin
            if (en_cnt < 2) addr_log[en_cnt] = rd_addr;
            en_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          reads;
        logic [31:0] a0;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic run_vec(input vec_t v);
        int unsigned t0;
        chk("ready_before", {31'b0, ld_ready}, 32'd1);
        en_cnt    = 0;
        ld_req    = 1'b1;
        ld_addr   = v.addr;
        ld_funct3 = v.f3;
        t0        = cyc;
        @(posedge clk) #2;
        ld_req = 1'b0;
        while (!ld_valid && (cyc - t0) < 12) @(posedge clk) #2;
        chk("valid_seen", {31'b0, ld_valid}, 32'd1);
        chk("latency", cyc - t0, v.lat);
        chk("data", ld_data, v.data);
        chk("err", {31'b0, ld_err}, {31'b0, v.err});
        @(posedge clk) #2;
        chk("valid_pulse", {31'b0, ld_valid}, 32'd0);
        chk("ready_after", {31'b0, ld_ready}, 32'd1);
        chk("data_hold", ld_data, v.data);
        chk("reads", en_cnt, v.reads);
        if (v.reads >= 1) chk("rd_addr0", addr_log[0], v.a0);
        if (v.reads == 2) chk("rd_addr1", addr_log[1], v.a0 + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0;
        int          nv;
        int unsigned vc [2];
        logic [31:0] vd [2];

        vecs[0]  = '{32'h103, 3'b000, 32'hFFFF_FF87, 1'b0, 3, 1, 32'h100};
        vecs[1]  = '{32'h102, 3'b001, 32'hFFFF_8765, 1'b0, 3, 1, 32'h100};
        vecs[2]  = '{32'h102, 3'b101, 32'h0000_8765, 1'b0, 3, 1, 32'h100};
        vecs[3]  = '{32'h100, 3'b100, 32'h0000_0021, 1'b0, 3, 1, 32'h100};
        vecs[4]  = '{32'h100, 3'b010, 32'h8765_4321, 1'b0, 3, 1, 32'h100};
        vecs[5]  = '{32'h101, 3'b000, 32'h0000_0043, 1'b0, 3, 1, 32'h100};
        vecs[6]  = '{32'h103, 3'b100, 32'h0000_0087, 1'b0, 3, 1, 32'h100};
        vecs[7]  = '{32'h100, 3'b011, 32'h0,         1'b1, 1, 0, 32'h0};
        vecs[8]  = '{32'h104, 3'b110, 32'h0,         1'b1, 1, 0, 32'h0};
        vecs[13] = '{32'h103, 3'b111, 32'h0,         1'b1, 1, 0, 32'h0};
        vecs[14] = '{32'h104, 3'b010, 32'hCAFE_BABE, 1'b0, 3, 1, 32'h104};
`ifdef MEM_LD_MISALIGN_EN
        vecs[9]  = '{32'h102,       3'b010, 32'hBABE_8765, 1'b0, 5, 2, 32'h100};
        vecs[10] = '{32'h101,       3'b001, 32'h0000_6543, 1'b0, 3, 1, 32'h100};
        vecs[11] = '{32'h103,       3'b001, 32'hFFFF_BE87, 1'b0, 5, 2, 32'h100};
        vecs[12] = '{32'hFFFF_FFFE, 3'b010, 32'h0000_1122, 1'b0, 5, 2, 32'hFFFF_FFFC};
`else
        vecs[9]  = '{32'h102,       3'b010, 32'h0, 1'b1, 1, 0, 32'h0};
        vecs[10] = '{32'h101,       3'b001, 32'h0, 1'b1, 1, 0, 32'h0};
        vecs[11] = '{32'h103,       3'b001, 32'h0, 1'b1, 1, 0, 32'h0};
        vecs[12] = '{32'hFFFF_FFFE, 3'b010, 32'h0, 1'b1, 1, 0, 32'h0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", {31'b0, ld_ready}, 32'd0);
        chk("rst_valid", {31'b0, ld_valid}, 32'd0);
        chk("rst_data", ld_data, 32'd0);
        chk("rst_err", {31'b0, ld_err}, 32'd0);
        chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_release", {31'b0, ld_ready}, 32'd1);
        @(posedge clk) #2;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset while waiting for the read to complete
        resp_en   = 1'b0;
        en_cnt    = 0;
        ld_req    = 1'b1;
        ld_addr   = 32'h100;
        ld_funct3 = 3'b010;
        @(posedge clk) #2;
        ld_req = 1'b0;
        @(posedge clk) #2;
        chk("mid_reads", en_cnt, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, ld_ready}, 32'd0);
        chk("mid_rst_data", ld_data, 32'd0);
        @(posedge clk) #2;
        rst   = 1'b0;
        stray = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk) #2;
            stray = 1'b0;
            chk("mid_no_valid", {31'b0, ld_valid}, 32'd0);
            chk("mid_ready", {31'b0, ld_ready}, 32'd1);
        end
        chk("mid_no_reads", en_cnt, 32'd1);
        resp_en = 1'b1;
        run_vec(vecs[4]);

        // Back-to-back with request held
        en_cnt    = 0;
        nv        = 0;
        ld_req    = 1'b1;
        ld_addr   = 32'h100;
        ld_funct3 = 3'b000;
        t0        = cyc;
        @(posedge clk) #2;
        ld_addr = 32'h101;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk) #2;
            if ((cyc - t0) == 5) ld_req = 1'b0;
            if (ld_valid) begin
                if (nv < 2) begin
                    vc[nv] = cyc - t0;
                    vd[nv] = ld_data;
                end
                nv++;
            end
        end
        ld_req = 1'b0;
        chk("b2b_count", nv, 32'd2);
        chk("b2b_lat0", vc[0], 32'd3);
        chk("b2b_data0", vd[0], 32'h0000_0021);
        chk("b2b_lat1", vc[1], 32'd7);
        chk("b2b_data1", vd[1], 32'h0000_0043);
        chk("b2b_reads", en_cnt, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
